alu_operand_loader: RTL and testbench
=====================================

// Module: alu_operand_loader
// PURPOSE
//  Upstream front-end of the 4-bit ALU. Sequences operand entry from board switches plus one push-button.
//  Each debounced press latches, in order: first operand, second operand, operation code.
//  Drives the ALU operand/opcode inputs from registers, so the ALU and 7-seg displays see stable values.
//  Reports the entry stage so the board can show which value is being keyed in.
// PARAMETERS
//  N                 4   operand width; matches ALU N
//  DEBOUNCE_CYCLES   16  consecutive stable cycles required to accept a button level change (>=2)
// PORTS
//  clk             in   1   system clock; all state on rising edge
//  rst             in   1   synchronous, active-high reset
//  switches        in   N   operand value from slide switches (asynchronous to clk)
//  op_sw           in   2   operation code from switches: 00 add, 01 sub, 10 div, 11 reserved
//  enter_btn       in   1   raw push-button, active-high, bouncing, asynchronous
//  clear_btn       in   1   raw clear button, active-high, asynchronous
//  first_num       out  N   registered first operand -> ALU firstNum
//  sec_num         out  N   registered second operand -> ALU secNum
//  operation       out  2   registered opcode -> ALU operation
//  stage           out  2   current FSM state (encoding below)
//  operands_valid  out  1   high while all three values are loaded (state S_RUN)
// BEHAVIOUR
//  Reset: first_num=0, sec_num=0, operation=2'b00, stage=S_A, operands_valid=0, debounce state cleared.
//  Input sync: enter_btn, clear_btn, switches, op_sw each pass a 2-FF synchronizer; logic uses synced copies.
//  Debounce (enter only): db_level reset 0; cnt counts cycles where sync_enter != db_level.
//   - cnt clears whenever sync_enter == db_level.
//   - When sync_enter has differed for DEBOUNCE_CYCLES consecutive cycles: db_level flips, cnt clears.
//   - enter_pulse = registered (db_level & ~db_level_q); exactly one cycle per accepted press.
//   - Holding the button yields one pulse; release produces none.
//  Latency: stable press -> enter_pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles; pulse -> output update +1 cycle.
//  FSM (stage encoding): S_A=00, S_B=01, S_OP=10, S_RUN=11.
//   - S_A   + enter_pulse: first_num <= sync_switches; -> S_B
//   - S_B   + enter_pulse: sec_num <= sync_switches; -> S_OP
//   - S_OP  + enter_pulse: operation <= sync_op_sw (11 stored unchanged; ALU treats as default); -> S_RUN
//   - S_RUN + enter_pulse: -> S_A; operand registers hold their values until overwritten.
//   - No enter_pulse: state and registers hold.
//  operands_valid = (stage == S_RUN); registered, so it rises in the same cycle operation updates.
//  Clear: sync_clear is level-sensitive, no debounce.
//   - While high: stage <= S_A, all operand/op registers <= 0, operands_valid <= 0.
//   - Clear outranks a coincident enter_pulse; that pulse is discarded.
//   - Debounce state is not affected by clear.
//  rst mid-press: debouncer returns to db_level=0.
//   - A button still held after rst deasserts is re-qualified as a new press after the full latency.
//  Switch changes outside an enter_pulse cycle have no effect on outputs.
// STRUCTURE
//  Package alu_pkg:
//   - typedef enum logic [1:0] stage_t {S_A, S_B, S_OP, S_RUN}
//   - localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_DIV=2'b10
//   - shared with ALU and its testbench
//  Sub-module button_debouncer #(DEBOUNCE_CYCLES) (clk, rst, btn_raw, pulse):
//   - contains the 2-FF sync, counter and edge detect
//   - counter width $clog2(DEBOUNCE_CYCLES+1)
//  Top:
//   - data synchronizers
//   - FSM (one always_ff plus next-state always_comb)
//   - operand registers
// TESTING (DEBOUNCE_CYCLES=4 in bench)
//  1. Reset then idle 20 cycles -> all outputs 0, stage=00, operands_valid=0.
//  2. Clean 3-press sequence, switches=4'h5 / 4'h3, op_sw=01 -> first_num=5, sec_num=3,
//     operation=01, stage=11, operands_valid=1; 4th press -> stage=00, values held.
//  3. Bounce: enter toggles every 2 cycles for 12 cycles, then stays high -> exactly one
//     pulse, first press latched only after 4 stable cycles; shorter glitch (3 cycles) -> no pulse.
//  4. Hold enter high 100 cycles in S_A, switches=4'hA -> first_num=A, stage=01, no further advance.
//  5. clear_btn asserted in S_OP on the same cycle as enter_pulse -> stage=00, all registers 0,
//     operation not loaded.
//  6. rst asserted mid-debounce (cnt=2) with enter held -> no pulse during reset;
//     pulse 2+4+1 cycles after rst falls.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: stage encoding and opcodes shared by the ALU front-end, the ALU and their benches
package alu_pkg;
  typedef enum logic [1:0] {S_A = 2'b00, S_B = 2'b01, S_OP = 2'b10, S_RUN = 2'b11} stage_t;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
endpackage

// File: rtl/alu_operand_loader_debouncer.sv
// button_debouncer: synchronizes a raw button and emits one pulse per accepted press
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic db_q, db_d, db_prev_q, pulse_q, differ, done;
  always_comb begin
    differ = sync_q[1] != db_q;
    done = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d = (!differ || done) ? '0 : cnt_q + 1'b1;
    db_d = done ? ~db_q : db_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      db_q <= 1'b0;
      db_prev_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      cnt_q <= cnt_d;
      db_q <= db_d;
      db_prev_q <= db_q;
      pulse_q <= db_q & ~db_prev_q;
    end
  end
  assign pulse = pulse_q;
endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: sequences first operand, second operand and opcode entry from one debounced button
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int N = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] switches,
  input  logic [1:0]   op_sw,
  input  logic         enter_btn,
  input  logic         clear_btn,
  output logic [N-1:0] first_num,
  output logic [N-1:0] sec_num,
  output logic [1:0]   operation,
  output logic [1:0]   stage,
  output logic         operands_valid
);
  logic [N-1:0] sw_s1_q, sw_s2_q, first_q, first_d, sec_q, sec_d;
  logic [1:0] op_s1_q, op_s2_q, clr_s_q, op_q, op_d;
  logic valid_q, valid_d, enter_pulse;
  stage_t stage_q, stage_d;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .rst(rst), .btn_raw(enter_btn), .pulse(enter_pulse)
  );
  always_comb begin
    stage_d = stage_q;
    first_d = first_q;
    sec_d = sec_q;
    op_d = op_q;
    if (clr_s_q[1]) begin
      stage_d = S_A;
      first_d = '0;
      sec_d = '0;
      op_d = '0;
    end else if (enter_pulse) begin
      first_d = (stage_q == S_A) ? sw_s2_q : first_q;
      sec_d = (stage_q == S_B) ? sw_s2_q : sec_q;
      op_d = (stage_q == S_OP) ? op_s2_q : op_q;
      stage_d = stage_t'(2'(stage_q) + 2'd1);
    end
    valid_d = stage_d == S_RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      op_s1_q <= '0;
      op_s2_q <= '0;
      clr_s_q <= '0;
      stage_q <= S_A;
      first_q <= '0;
      sec_q <= '0;
      op_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sw_s1_q <= switches;
      sw_s2_q <= sw_s1_q;
      op_s1_q <= op_sw;
      op_s2_q <= op_s1_q;
      clr_s_q <= {clr_s_q[0], clear_btn};
      stage_q <= stage_d;
      first_q <= first_d;
      sec_q <= sec_d;
      op_q <= op_d;
      valid_q <= valid_d;
    end
  end
  assign first_num = first_q;
  assign sec_num = sec_q;
  assign operation = op_q;
  assign stage = stage_q;
  assign operands_valid = valid_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed stimulus against a cycle model plus literal checkpoints
module tb_alu_operand_loader;
  localparam int D = 4;
  logic clk = 0, rst = 1, enter_btn = 0, clear_btn = 0;
  logic [3:0] switches = 0, first_num, sec_num;
  logic [1:0] op_sw = 0, operation, stage;
  logic operands_valid;
  int n_checks = 0, n_fail = 0, latency;
  alu_operand_loader #(.N(4), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .switches(switches), .op_sw(op_sw), .enter_btn(enter_btn),
    .clear_btn(clear_btn), .first_num(first_num), .sec_num(sec_num), .operation(operation),
    .stage(stage), .operands_valid(operands_valid)
  );
  always #5 clk = ~clk;
  // model: inputs seen two edges late, press accepted after D differing samples, loads one cycle after pulse
  bit armed = 0, e1, e2, c1, c2, lvl, rose, pulse, m_valid;
  logic [3:0] sw1, sw2, m_first, m_sec;
  logic [1:0] o1, o2, m_op;
  int run, m_stage;
  always @(posedge clk) begin
    if (rst) begin
      armed = 1; e1 = 0; e2 = 0; c1 = 0; c2 = 0; sw1 = 0; sw2 = 0; o1 = 0; o2 = 0;
      lvl = 0; run = 0; rose = 0; pulse = 0;
      m_first = 0; m_sec = 0; m_op = 0; m_stage = 0; m_valid = 0;
    end else begin
      if (c2) begin
        m_first = 0; m_sec = 0; m_op = 0; m_stage = 0;
      end else if (pulse) begin
        if (m_stage == 0) m_first = sw2;
        if (m_stage == 1) m_sec = sw2;
        if (m_stage == 2) m_op = o2;
        m_stage = (m_stage + 1) % 4;
      end
      m_valid = m_stage == 3;
      pulse = rose;
      rose = 0;
      if (e2 != lvl) begin
        run++;
        if (run == D) begin lvl = ~lvl; run = 0; rose = lvl; end
      end else run = 0;
      e2 = e1; e1 = enter_btn; c2 = c1; c1 = clear_btn;
      sw2 = sw1; sw1 = switches; o2 = o1; o1 = op_sw;
    end
  end
  always @(negedge clk) if (armed) begin
    n_checks++;
    if ({first_num, sec_num, operation, stage, operands_valid} !== {m_first, m_sec, m_op, 2'(m_stage), m_valid}) begin
      n_fail++;
      $display("FAIL model t=%0t got first=%h sec=%h op=%h stage=%h valid=%b want first=%h sec=%h op=%h stage=%h valid=%b",
               $time, first_num, sec_num, operation, stage, operands_valid, m_first, m_sec, m_op, 2'(m_stage), m_valid);
    end
  end
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press();
    enter_btn = 1; cyc(12); enter_btn = 0; cyc(12);
  endtask
  initial begin
    cyc(3); rst = 0; cyc(20);
    check("reset_first", first_num, 0); check("reset_sec", sec_num, 0);
    check("reset_op", operation, 0); check("reset_stage", stage, 0); check("reset_valid", operands_valid, 0);
    switches = 4'h5; press(); switches = 4'h3; press(); op_sw = 2'b01; press();
    check("seq_first", first_num, 5); check("seq_sec", sec_num, 3); check("seq_op", operation, 1);
    check("seq_stage", stage, 3); check("seq_valid", operands_valid, 1);
    switches = 4'hF; press();
    check("wrap_stage", stage, 0); check("wrap_first", first_num, 5); check("wrap_valid", operands_valid, 0);
    switches = 4'h9;
    for (int i = 0; i < 6; i++) begin enter_btn = (i % 2 == 0); cyc(2); end
    enter_btn = 1; cyc(7);
    check("bounce_not_yet", stage, 0);
    cyc(1);
    check("bounce_stage", stage, 1); check("bounce_first", first_num, 9);
    cyc(4); enter_btn = 0; cyc(12);
    switches = 4'h2; enter_btn = 1; cyc(3); enter_btn = 0; cyc(15);
    check("glitch_stage", stage, 1); check("glitch_sec", sec_num, 3);
    clear_btn = 1; cyc(4); clear_btn = 0; cyc(4);
    check("clear_stage", stage, 0); check("clear_first", first_num, 0);
    switches = 4'hA; enter_btn = 1; cyc(100);
    check("hold_first", first_num, 10); check("hold_stage", stage, 1);
    enter_btn = 0; cyc(12);
    switches = 4'h7; press();
    check("pre_clr_stage", stage, 2); check("pre_clr_sec", sec_num, 7);
    op_sw = 2'b10; enter_btn = 1; cyc(5); clear_btn = 1; cyc(6);
    check("clr_stage", stage, 0); check("clr_sec", sec_num, 0); check("clr_op", operation, 0);
    clear_btn = 0; cyc(12);
    check("clr_discard_stage", stage, 0);
    enter_btn = 0; cyc(12);
    switches = 4'h6; enter_btn = 1; cyc(4); rst = 1; cyc(3); rst = 0;
    latency = 31;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (stage == 2'b01) begin latency = i; break; end
    end
    check("rst_latency", latency, 8); check("rst_first", first_num, 6);
    enter_btn = 0; cyc(12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
